// File: rtl/uart_cmd_pkg.sv
// Shared definitions for the UART command decoder: opcodes, FSM states and the
// fixed register addresses that receive ALU operands.
package uart_cmd_pkg;

    localparam logic [7:0] OPC_WRITE     = 8'hAA;
    localparam logic [7:0] OPC_READ      = 8'hBB;
    localparam logic [7:0] OPC_ALU_OPS   = 8'hCC;
    localparam logic [7:0] OPC_ALU_NOOPS = 8'hDD;

    localparam int unsigned OPERAND_A_ADDR = 0;
    localparam int unsigned OPERAND_B_ADDR = 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_ADDR,
        ST_WR_DATA,
        ST_RD_ADDR,
        ST_ALU_A,
        ST_ALU_B,
        ST_ALU_FUN
    } cmd_state_e;

endpackage

// File: rtl/rx_frame_timer.sv
// Inter-byte gap counter: flags expiry when a frame in progress has seen no
// byte for Timeout_cycles clock cycles.
module rx_frame_timer #(
    parameter int unsigned Timeout_cycles = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic busy,
    input  logic clear,
    output logic expired
);

    localparam int unsigned CntW = (Timeout_cycles > 2) ? $clog2(Timeout_cycles) : 1;
    localparam logic [CntW-1:0] LastCount = CntW'(Timeout_cycles - 1);

    logic [CntW-1:0] count;

    // Expiry wins over a byte arriving on the same cycle; that byte then opens a new frame.
    assign expired = busy && (count == LastCount);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (!busy || clear || expired) begin
            count <= '0;
        end else begin
            count <= count + CntW'(1);
        end
    end

endmodule

// File: rtl/uart_rx_cmd_decoder.sv
// Parses the received UART byte stream into register-file and ALU strobes.
// Optional inter-byte timeout is enabled by defining CMD_TIMEOUT_EN.
module uart_rx_cmd_decoder
    import uart_cmd_pkg::*;
#(
    parameter int unsigned Data_width     = 8,
    parameter int unsigned Addr_width     = 4,
    parameter int unsigned Timeout_cycles = 1024
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [Data_width-1:0] RX_P_DATA,
    input  logic                  RX_D_VLD,
    input  logic                  RX_PAR_ERR,
    input  logic                  RX_STP_ERR,
    output logic                  WrEn,
    output logic                  RdEn,
    output logic [Addr_width-1:0] Address,
    output logic [Data_width-1:0] WrData,
    output logic                  ALU_EN,
    output logic [3:0]            ALU_FUN,
    output logic                  FRM_ERR,
    output logic                  Busy
);

    if (Data_width < 8 || Addr_width > Data_width || Timeout_cycles < 2) begin : g_param_check
        $error("uart_rx_cmd_decoder: unsupported parameter combination");
    end

    cmd_state_e            state, state_nxt, dec_state;
    logic [Addr_width-1:0] addr_lat, addr_lat_nxt, address_nxt;
    logic [Data_width-1:0] wr_data_nxt;
    logic [3:0]            alu_fun_nxt;
    logic                  wr_en_nxt, rd_en_nxt, alu_en_nxt, frm_err_nxt;
    logic                  timeout_expired;

`ifdef CMD_TIMEOUT_EN
    rx_frame_timer #(
        .Timeout_cycles(Timeout_cycles)
    ) u_frame_timer (
        .clk     (CLK),
        .rst_n   (RST),
        .busy    (state != ST_IDLE),
        .clear   (RX_D_VLD),
        .expired (timeout_expired)
    );
`else
    assign timeout_expired = 1'b0;
`endif

    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_nxt    = state;
        dec_state    = state;
        addr_lat_nxt = addr_lat;
        address_nxt  = Address;
        wr_data_nxt  = WrData;
        alu_fun_nxt  = ALU_FUN;
        wr_en_nxt    = 1'b0;
        rd_en_nxt    = 1'b0;
        alu_en_nxt   = 1'b0;
        frm_err_nxt  = 1'b0;

        if (timeout_expired) begin
            dec_state   = ST_IDLE;
            state_nxt   = ST_IDLE;
            frm_err_nxt = 1'b1;
        end

        if (RX_D_VLD) begin
            if (RX_PAR_ERR || RX_STP_ERR) begin
                state_nxt   = ST_IDLE;
                frm_err_nxt = 1'b1;
            end else begin
                // Opcodes are only decoded from IDLE; elsewhere every byte is payload.
                case (dec_state)
                    ST_IDLE: begin
                        case (RX_P_DATA)
                            Data_width'(OPC_WRITE):     state_nxt = ST_WR_ADDR;
                            Data_width'(OPC_READ):      state_nxt = ST_RD_ADDR;
                            Data_width'(OPC_ALU_OPS):   state_nxt = ST_ALU_A;
                            Data_width'(OPC_ALU_NOOPS): state_nxt = ST_ALU_FUN;
                            default: begin
                                state_nxt   = ST_IDLE;
                                frm_err_nxt = 1'b1;
                            end
                        endcase
                    end
                    ST_WR_ADDR: begin
                        addr_lat_nxt = RX_P_DATA[Addr_width-1:0];
                        state_nxt    = ST_WR_DATA;
                    end
                    ST_WR_DATA: begin
                        wr_en_nxt   = 1'b1;
                        address_nxt = addr_lat;
                        wr_data_nxt = RX_P_DATA;
                        state_nxt   = ST_IDLE;
                    end
                    ST_RD_ADDR: begin
                        rd_en_nxt   = 1'b1;
                        address_nxt = RX_P_DATA[Addr_width-1:0];
                        state_nxt   = ST_IDLE;
                    end
                    ST_ALU_A: begin
                        wr_en_nxt   = 1'b1;
                        address_nxt = Addr_width'(OPERAND_A_ADDR);
                        wr_data_nxt = RX_P_DATA;
                        state_nxt   = ST_ALU_B;
                    end
                    ST_ALU_B: begin
                        wr_en_nxt   = 1'b1;
                        address_nxt = Addr_width'(OPERAND_B_ADDR);
                        wr_data_nxt = RX_P_DATA;
                        state_nxt   = ST_ALU_FUN;
                    end
                    ST_ALU_FUN: begin
                        alu_en_nxt  = 1'b1;
                        alu_fun_nxt = RX_P_DATA[3:0];
                        state_nxt   = ST_IDLE;
                    end
                    default: state_nxt = ST_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state    <= ST_IDLE;
            addr_lat <= '0;
            WrEn     <= 1'b0;
            RdEn     <= 1'b0;
            ALU_EN   <= 1'b0;
            FRM_ERR  <= 1'b0;
            Busy     <= 1'b0;
            Address  <= '0;
            WrData   <= '0;
            ALU_FUN  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state    <= state_nxt;
            addr_lat <= addr_lat_nxt;
            WrEn     <= wr_en_nxt;
            RdEn     <= rd_en_nxt;
            ALU_EN   <= alu_en_nxt;
            FRM_ERR  <= frm_err_nxt;
            Busy     <= (state_nxt != ST_IDLE);
            Address  <= address_nxt;
            WrData   <= wr_data_nxt;
            ALU_FUN  <= alu_fun_nxt;
        end
    end

endmodule

// File: tb/tb_uart_rx_cmd_decoder.sv
// Directed bench for uart_rx_cmd_decoder: frame decoding, errors, reset and
// the idle-gap behaviour in either build of CMD_TIMEOUT_EN.
module tb_uart_rx_cmd_decoder;

    localparam int TO = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_vld = 1'b0;
    logic       rx_pe = 1'b0;
    logic       rx_se = 1'b0;
    logic       wr_en, rd_en, alu_en, frm_err, busy;
    logic [3:0] address;
    logic [7:0] wr_data;
    logic [3:0] alu_fun;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    uart_rx_cmd_decoder #(
        .Data_width     (8),
        .Addr_width     (4),
        .Timeout_cycles (TO)
    ) dut (
        .CLK        (clk),
        .RST        (rst_n),
        .RX_P_DATA  (rx_data),
        .RX_D_VLD   (rx_vld),
        .RX_PAR_ERR (rx_pe),
        .RX_STP_ERR (rx_se),
        .WrEn       (wr_en),
        .RdEn       (rd_en),
        .Address    (address),
        .WrData     (wr_data),
        .ALU_EN     (alu_en),
        .ALU_FUN    (alu_fun),
        .FRM_ERR    (frm_err),
        .Busy       (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Control bits packed as {WrEn, RdEn, ALU_EN, FRM_ERR, Busy}.
    task automatic check_ctl(input string tag, input logic [4:0] exp);
        check({tag, " ctl"}, 32'({wr_en, rd_en, alu_en, frm_err, busy}), 32'(exp));
    endtask

    task automatic drive(input logic [7:0] b, input logic pe, input logic se);
        @(negedge clk);
        rx_vld  = 1'b1;
        rx_data = b;
        rx_pe   = pe;
        rx_se   = se;
    endtask

    task automatic idle();
        @(negedge clk);
        rx_vld = 1'b0;
        rx_pe  = 1'b0;
        rx_se  = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_ctl("reset", 5'b00000);
        check("reset addr", 32'(address), 32'h0);
        check("reset wdata", 32'(wr_data), 32'h0);
        check("reset fun", 32'(alu_fun), 32'h0);
        rst_n = 1'b1;
        idle();

        // Write frame with idle gaps between bytes.
        drive(8'hAA, 0, 0); idle(); check_ctl("wr opc", 5'b00001);
        drive(8'h05, 0, 0); idle(); check_ctl("wr addr", 5'b00001);
        drive(8'h3C, 0, 0); idle(); check_ctl("wr strobe", 5'b10000);
        check("wr address", 32'(address), 32'h5);
        check("wr data", 32'(wr_data), 32'h3C);
        idle(); check_ctl("wr one-shot", 5'b00000);
        check("wr addr hold", 32'(address), 32'h5);

        // Read frame, back-to-back bytes.
        drive(8'hBB, 0, 0); drive(8'h0A, 0, 0); check_ctl("rd opc", 5'b00001);
        idle(); check_ctl("rd strobe", 5'b01000);
        check("rd address", 32'(address), 32'hA);
        check("rd wdata hold", 32'(wr_data), 32'h3C);

        // ALU without operands.
        drive(8'hDD, 0, 0); drive(8'h02, 0, 0); idle();
        check_ctl("alu0 strobe", 5'b00100);
        check("alu0 fun", 32'(alu_fun), 32'h2);

        // ALU with operands, all bytes back-to-back.
        drive(8'hCC, 0, 0); drive(8'h11, 0, 0); check_ctl("alu opc", 5'b00001);
        drive(8'h22, 0, 0); check_ctl("alu A", 5'b10001);
        check("alu A addr", 32'(address), 32'h0);
        check("alu A data", 32'(wr_data), 32'h11);
        drive(8'h03, 0, 0); check_ctl("alu B", 5'b10001);
        check("alu B addr", 32'(address), 32'h1);
        check("alu B data", 32'(wr_data), 32'h22);
        idle(); check_ctl("alu exec", 5'b00100);
        check("alu fun", 32'(alu_fun), 32'h3);

        // Parity error on the data byte drops the write.
        drive(8'hAA, 0, 0); drive(8'h05, 0, 0); drive(8'h3C, 1, 0); idle();
        check_ctl("par err", 5'b00010);
        check("par err addr hold", 32'(address), 32'h1);
        check("par err data hold", 32'(wr_data), 32'h22);
        drive(8'hBB, 0, 0); drive(8'h01, 0, 0); idle();
        check_ctl("after par rd", 5'b01000);
        check("after par addr", 32'(address), 32'h1);

        // Stop error on a read address, then a valid opcode carrying a stop error.
        drive(8'hBB, 0, 0); drive(8'h0E, 0, 1); idle(); check_ctl("stp err", 5'b00010);
        drive(8'hDD, 0, 1); idle(); check_ctl("stp err opc", 5'b00010);
        drive(8'hBB, 0, 0); drive(8'h0C, 0, 0); idle();
        check_ctl("after stp rd", 5'b01000);
        check("after stp addr", 32'(address), 32'hC);

        // Unknown opcode in IDLE.
        drive(8'h7F, 0, 0); idle(); check_ctl("unknown opc", 5'b00010);
        idle(); check_ctl("err one-shot", 5'b00000);

        // Opcode values as payload, and address truncated to the low nibble.
        drive(8'hAA, 0, 0); drive(8'hF7, 0, 0); drive(8'hBB, 0, 0); idle();
        check_ctl("payload wr", 5'b10000);
        check("payload addr", 32'(address), 32'h7);
        check("payload data", 32'(wr_data), 32'hBB);

        // Reset in the middle of a frame.
        drive(8'hAA, 0, 0); drive(8'h05, 0, 0); idle(); check_ctl("pre-rst", 5'b00001);
        rst_n = 1'b0;
        #1;
        check_ctl("mid rst", 5'b00000);
        check("mid rst addr", 32'(address), 32'h0);
        check("mid rst wdata", 32'(wr_data), 32'h0);
        check("mid rst fun", 32'(alu_fun), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(8'h3C, 0, 0); idle(); check_ctl("post rst 3C", 5'b00010);

        // Idle gap after an opcode.
        drive(8'hAA, 0, 0); idle();
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
`ifdef CMD_TIMEOUT_EN
            check_ctl($sformatf("gap %0d", k),
                      (k == TO) ? 5'b00010 : ((k < TO) ? 5'b00001 : 5'b00000));
`else
            check_ctl($sformatf("gap %0d", k), 5'b00001);
`endif
        end
`ifdef CMD_TIMEOUT_EN
        drive(8'h05, 0, 0); idle(); check_ctl("post timeout 05", 5'b00010);
`else
        drive(8'h05, 0, 0); drive(8'h3C, 0, 0); idle();
        check_ctl("late wr", 5'b10000);
        check("late wr addr", 32'(address), 32'h5);
        check("late wr data", 32'(wr_data), 32'h3C);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_rx_cmd_decoder.md
# uart_rx_cmd_decoder

Consumes the byte stream delivered by the UART receiver (already synchronized into the system clock domain) and parses it into register-file and ALU commands. It sits between the UART RX path and the register file / ALU, converting multi-byte frames into single-cycle strobes with address, data and function fields. Malformed or errored frames are dropped and flagged.

## Interface
- `Data_width`, 8, byte width of received data.
- `Addr_width`, 4, register-file address width; the low `Addr_width` bits of the address byte are used.
- `Timeout_cycles`, 1024, idle-gap limit in CLK cycles; used only with `CMD_TIMEOUT_EN`.

- `CLK` input 1: system clock.
- `RST` input 1: asynchronous, active-low reset.
- `RX_P_DATA` input Data_width: received byte.
- `RX_D_VLD` input 1: one-cycle pulse per received byte.
- `RX_PAR_ERR` input 1: parity error for the byte qualified by `RX_D_VLD`.
- `RX_STP_ERR` input 1: stop-bit error for the byte qualified by `RX_D_VLD`.
- `WrEn` output 1: register write strobe, one cycle.
- `RdEn` output 1: register read strobe, one cycle.
- `Address` output Addr_width: register address, valid with `WrEn`/`RdEn`.
- `WrData` output Data_width: write data, valid with `WrEn`.
- `ALU_EN` output 1: ALU execute strobe, one cycle.
- `ALU_FUN` output 4: ALU function, valid with `ALU_EN`.
- `FRM_ERR` output 1: one-cycle pulse when a frame is aborted.
- `Busy` output 1: high whenever state ≠ IDLE.

## Operation
- Byte accepted on any CLK edge with `RX_D_VLD`=1. A byte with `RX_PAR_ERR` or `RX_STP_ERR` set is discarded: FSM returns to IDLE, `FRM_ERR` pulses.
- Opcodes, first byte of a frame:
  - 0xAA write: addr, data.
  - 0xBB read: addr.
  - 0xCC ALU with operands: A, B, func.
  - 0xDD ALU without operands: func.
- States: IDLE, WR_ADDR, WR_DATA, RD_ADDR, ALU_A, ALU_B, ALU_FUN.
  - IDLE: 0xAA→WR_ADDR, 0xBB→RD_ADDR, 0xCC→ALU_A, 0xDD→ALU_FUN. Any other byte: stay in IDLE, pulse `FRM_ERR`.
  - WR_ADDR: latch address, →WR_DATA.
  - WR_DATA: `WrEn` pulse with latched `Address` and byte on `WrData`, →IDLE.
  - RD_ADDR: `RdEn` pulse with `Address`=byte, →IDLE.
  - ALU_A: `WrEn` to address 0 with A, →ALU_B.
  - ALU_B: `WrEn` to address 1 with B, →ALU_FUN.
  - ALU_FUN: `ALU_EN` pulse, `ALU_FUN`=byte[3:0], →IDLE.
- Opcode values are not recognized in non-IDLE states; every byte is treated as payload.
- Only one strobe (`WrEn`, `RdEn` or `ALU_EN`) is ever high in a given cycle.

## Timing
- All outputs are registered. A strobe appears the cycle after the accepting edge and lasts exactly one cycle.
- `Address`, `WrData` and `ALU_FUN` hold their last value between strobes.
- Back-to-back `RX_D_VLD` on consecutive cycles is supported; each byte is consumed on its own edge.
- Reset (async assert, any time including mid-frame): state=IDLE; `WrEn`, `RdEn`, `ALU_EN`, `FRM_ERR` and `Busy` are 0; `Address`, `WrData` and `ALU_FUN` are 0. The partial frame is lost and no strobe is emitted.
- `FRM_ERR` is raised on the cycle after the offending byte, or after timeout expiry.

## Configuration
- `CMD_TIMEOUT_EN` defined:
  - A gap counter runs while state ≠ IDLE and clears on each accepted byte.
  - When it reaches `Timeout_cycles`: →IDLE, `FRM_ERR` pulses, no strobe.
  - A byte arriving on the expiry cycle is consumed as the first byte of a new frame.
- `CMD_TIMEOUT_EN` undefined: no counter; the FSM waits indefinitely for the next byte.

## Structure
- Shared package `uart_cmd_pkg`: opcode constants (0xAA/0xBB/0xCC/0xDD), state enum, operand addresses 0 and 1.
- Sub-module `rx_frame_timer`: the gap counter, instantiated only under `CMD_TIMEOUT_EN`.

## Test plan
- Frame AA,05,3C → one `WrEn` pulse with `Address`=5 and `WrData`=0x3C; `Busy` high from byte 1 until the strobe.
- Frame BB,0A → `RdEn` with `Address`=0xA. Frame DD,02 → `ALU_EN` with `ALU_FUN`=2.
- Frame CC,11,22,03 → `WrEn`(0,0x11), then `WrEn`(1,0x22), then `ALU_EN`(3), all on back-to-back `RX_D_VLD` pulses.
- Frame AA,05 with `RX_PAR_ERR` on the data byte → no `WrEn`, `FRM_ERR` pulse, next frame BB,01 decodes correctly. Unknown opcode 0x7F in IDLE → `FRM_ERR`.
- `RST` low after AA,05 → all outputs 0; subsequent byte 0x3C is treated as an unknown opcode → `FRM_ERR`.
- With `CMD_TIMEOUT_EN` and `Timeout_cycles`=16: AA followed by 20 idle cycles → `FRM_ERR` at cycle 16, state IDLE; without the macro, a late 05,3C still produces `WrEn`.
